instruction_fetch_unit: RTL and testbench

Drives the fetch side of the instruction memory interface: owns the program counter, generates `address`, `stall` and `kill` toward the instruction memory, and resolves redirects from ID (jump/call/return) and EX (taken branch). A small return-address stack (RAS) supplies return targets. It sits between the hazard/branch logic and the synchronous instruction memory. The memory registers `instruction <= mem[address]` on each rising edge, or a NOP when `kill` is high, or holds when `stall` is high.

---
 rtl/instruction_fetch_unit_if.sv | 28 ++
 rtl/instruction_fetch_unit.sv | 66 ++++++
 tb/tb_instruction_fetch_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: fetch bus between hazard/branch logic, the fetch unit and instruction memory
// Inputs to the fetch unit: stall_in, branch_taken/branch_target, jump/jump_target, call, ret.
// Outputs from the fetch unit: address, stall, kill, flush_id, if_pc, if_valid, ras_empty, ras_full.
interface instruction_fetch_unit_if;
  logic        stall_in;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        jump;
  logic [15:0] jump_target;
  logic        call;
  logic        ret;
  logic [15:0] address;
  logic        stall;
  logic        kill;
  logic        flush_id;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        ras_empty;
  logic        ras_full;
  modport master (
    input  stall_in, branch_taken, branch_target, jump, jump_target, call, ret,
    output address, stall, kill, flush_id, if_pc, if_valid, ras_empty, ras_full
  );
  modport slave (
    output stall_in, branch_taken, branch_target, jump, jump_target, call, ret,
    input  address, stall, kill, flush_id, if_pc, if_valid, ras_empty, ras_full
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: program counter, memory stall/kill and jump/call/ret/branch redirect with a return-address stack
// Ports: clk, rst_n (async active-low), bus_io (master side of instruction_fetch_unit_if).
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          RAS_DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  instruction_fetch_unit_if.master bus_io
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);
  logic [15:0]   pc_q, pc_d, if_pc_q, if_pc_d, ras_top;
  logic          if_valid_q, if_valid_d;
  logic [15:0]   ras_q [RAS_DEPTH];
  logic [PW-1:0] top_q, top_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          id_ok, push, pop, kill, stall, empty;
  assign id_ok = !bus_io.stall_in && !bus_io.branch_taken;
  assign push  = bus_io.call && bus_io.jump && id_ok;
  // A call in the same cycle wins over a return
  assign pop   = bus_io.ret && id_ok && !push;
  assign empty = cnt_q == '0;
  assign kill  = rst_n && (bus_io.branch_taken || (id_ok && (bus_io.jump || bus_io.ret)));
  assign stall = rst_n && bus_io.stall_in && !bus_io.branch_taken;
  assign ras_top = empty ? RESET_PC : ras_q[top_q];
  always_comb begin
    pc_d = bus_io.branch_taken ? bus_io.branch_target :
           bus_io.stall_in     ? pc_q :
           pop                 ? ras_top :
           bus_io.jump         ? bus_io.jump_target : pc_q + 16'd1;
    if_pc_d    = stall ? if_pc_q : pc_q;
    if_valid_d = stall ? if_valid_q : !kill;
    // Pushing when full lets the circular pointer overwrite the oldest entry
    top_d = push ? top_q + PW'(1) : (pop && !empty) ? top_q - PW'(1) : top_q;
    cnt_d = push ? ((cnt_q == FULL) ? cnt_q : cnt_q + (PW+1)'(1)) :
            (pop && !empty) ? cnt_q - (PW+1)'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      if_pc_q    <= RESET_PC;
      if_valid_q <= 1'b0;
      top_q      <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      top_q      <= top_d;
      cnt_q      <= cnt_d;
    end
  end
  // Stack storage needs no reset: entries are only read while count is nonzero
  always_ff @(posedge clk) begin
    if (push) ras_q[top_d] <= if_pc_q + 16'd1;
  end
  assign bus_io.address   = pc_q;
  assign bus_io.stall     = stall;
  assign bus_io.kill      = kill;
  assign bus_io.flush_id  = rst_n && bus_io.branch_taken;
  assign bus_io.if_pc     = if_pc_q;
  assign bus_io.if_valid  = if_valid_q;
  assign bus_io.ras_empty = empty;
  assign bus_io.ras_full  = cnt_q == FULL;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  instruction_fetch_unit_if bus();
  instruction_fetch_unit #(.RESET_PC(16'h0000), .RAS_DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall_in = 0; bus.branch_taken = 0; bus.branch_target = 0;
    bus.jump = 0; bus.jump_target = 0; bus.call = 0; bus.ret = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    #1;
    rst_n = 0;
    idle();
    bus.stall_in = 1; bus.branch_taken = 1; bus.jump = 1; bus.ret = 1;
    #1;
    checks++; if (bus.address !== 16'h0000) begin failures++; $display("FAIL rst_address got=%h exp=0000", bus.address); end
    checks++; if (bus.if_pc !== 16'h0000) begin failures++; $display("FAIL rst_if_pc got=%h exp=0000", bus.if_pc); end
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL rst_if_valid got=%b exp=0", bus.if_valid); end
    checks++; if (bus.ras_empty !== 1'b1) begin failures++; $display("FAIL rst_ras_empty got=%b exp=1", bus.ras_empty); end
    checks++; if (bus.ras_full !== 1'b0) begin failures++; $display("FAIL rst_ras_full got=%b exp=0", bus.ras_full); end
    checks++; if (bus.kill !== 1'b0) begin failures++; $display("FAIL rst_kill got=%b exp=0", bus.kill); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.flush_id !== 1'b0) begin failures++; $display("FAIL rst_flush_id got=%b exp=0", bus.flush_id); end
    idle();
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic test_free_run();
    do_reset();
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL run_valid0 got=%b exp=0", bus.if_valid); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (bus.address !== 16'(i)) begin failures++; $display("FAIL run_address got=%h exp=%h", bus.address, 16'(i)); end
      checks++; if (bus.if_pc !== 16'(i - 1)) begin failures++; $display("FAIL run_if_pc got=%h exp=%h", bus.if_pc, 16'(i - 1)); end
      checks++; if (bus.if_valid !== 1'b1) begin failures++; $display("FAIL run_valid got=%b exp=1", bus.if_valid); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (5) tick();
    bus.stall_in = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL stall_out got=%b exp=1", bus.stall); end
      checks++; if (bus.kill !== 1'b0) begin failures++; $display("FAIL stall_kill got=%b exp=0", bus.kill); end
      checks++; if (bus.address !== 16'h0005) begin failures++; $display("FAIL stall_address got=%h exp=0005", bus.address); end
      checks++; if (bus.if_pc !== 16'h0004) begin failures++; $display("FAIL stall_if_pc got=%h exp=0004", bus.if_pc); end
      tick();
    end
    bus.stall_in = 0;
    #1;
    checks++; if (bus.address !== 16'h0005) begin failures++; $display("FAIL stall_hold got=%h exp=0005", bus.address); end
    checks++; if (bus.if_pc !== 16'h0004) begin failures++; $display("FAIL stall_if_pc_hold got=%h exp=0004", bus.if_pc); end
    checks++; if (bus.if_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b exp=1", bus.if_valid); end
    tick();
    checks++; if (bus.address !== 16'h0006) begin failures++; $display("FAIL stall_resume6 got=%h exp=0006", bus.address); end
    tick();
    checks++; if (bus.address !== 16'h0007) begin failures++; $display("FAIL stall_resume7 got=%h exp=0007", bus.address); end
    checks++; if (bus.if_pc !== 16'h0006) begin failures++; $display("FAIL stall_resume_pc got=%h exp=0006", bus.if_pc); end
  endtask

  task automatic test_jump();
    do_reset();
    repeat (3) tick();
    bus.jump = 1; bus.jump_target = 16'h0040;
    #1;
    checks++; if (bus.kill !== 1'b1) begin failures++; $display("FAIL jump_kill got=%b exp=1", bus.kill); end
    checks++; if (bus.flush_id !== 1'b0) begin failures++; $display("FAIL jump_flush got=%b exp=0", bus.flush_id); end
    tick();
    idle();
    checks++; if (bus.address !== 16'h0040) begin failures++; $display("FAIL jump_address got=%h exp=0040", bus.address); end
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL jump_bubble got=%b exp=0", bus.if_valid); end
    tick();
    checks++; if (bus.if_pc !== 16'h0040) begin failures++; $display("FAIL jump_if_pc got=%h exp=0040", bus.if_pc); end
    checks++; if (bus.if_valid !== 1'b1) begin failures++; $display("FAIL jump_valid got=%b exp=1", bus.if_valid); end
    checks++; if (bus.address !== 16'h0041) begin failures++; $display("FAIL jump_next got=%h exp=0041", bus.address); end
  endtask

  task automatic test_call_ret();
    do_reset();
    bus.jump = 1; bus.jump_target = 16'h0010;
    tick();
    idle();
    tick();
    checks++; if (bus.if_pc !== 16'h0010) begin failures++; $display("FAIL call_setup got=%h exp=0010", bus.if_pc); end
    checks++; if (bus.ras_empty !== 1'b1) begin failures++; $display("FAIL call_empty0 got=%b exp=1", bus.ras_empty); end
    bus.call = 1; bus.jump = 1; bus.jump_target = 16'h0080;
    tick();
    idle();
    checks++; if (bus.address !== 16'h0080) begin failures++; $display("FAIL call_address got=%h exp=0080", bus.address); end
    checks++; if (bus.ras_empty !== 1'b0) begin failures++; $display("FAIL call_empty1 got=%b exp=0", bus.ras_empty); end
    tick();
    bus.ret = 1;
    #1;
    checks++; if (bus.kill !== 1'b1) begin failures++; $display("FAIL ret_kill got=%b exp=1", bus.kill); end
    tick();
    idle();
    checks++; if (bus.address !== 16'h0011) begin failures++; $display("FAIL ret_address got=%h exp=0011", bus.address); end
    checks++; if (bus.ras_empty !== 1'b1) begin failures++; $display("FAIL ret_empty2 got=%b exp=1", bus.ras_empty); end
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL ret_bubble got=%b exp=0", bus.if_valid); end
  endtask

  task automatic test_branch_priority();
    do_reset();
    repeat (2) tick();
    bus.branch_taken = 1; bus.branch_target = 16'h0020;
    bus.jump = 1; bus.call = 1; bus.jump_target = 16'h0080; bus.stall_in = 1;
    #1;
    checks++; if (bus.kill !== 1'b1) begin failures++; $display("FAIL br_kill got=%b exp=1", bus.kill); end
    checks++; if (bus.flush_id !== 1'b1) begin failures++; $display("FAIL br_flush got=%b exp=1", bus.flush_id); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL br_stall got=%b exp=0", bus.stall); end
    tick();
    idle();
    checks++; if (bus.address !== 16'h0020) begin failures++; $display("FAIL br_address got=%h exp=0020", bus.address); end
    checks++; if (bus.ras_empty !== 1'b1) begin failures++; $display("FAIL br_ras got=%b exp=1", bus.ras_empty); end
    checks++; if (bus.if_pc !== 16'h0002) begin failures++; $display("FAIL br_if_pc got=%h exp=0002", bus.if_pc); end
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL br_bubble got=%b exp=0", bus.if_valid); end
  endtask

  task automatic test_ras_overflow();
    logic [15:0] exp_ret [5];
    exp_ret = '{16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0000};
    do_reset();
    repeat (2) tick();
    for (int k = 0; k < 5; k++) begin
      bus.call = 1; bus.jump = 1; bus.jump_target = 16'(k + 3);
      tick();
    end
    idle();
    checks++; if (bus.ras_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", bus.ras_full); end
    checks++; if (bus.if_pc !== 16'h0006) begin failures++; $display("FAIL ovf_if_pc got=%h exp=0006", bus.if_pc); end
    for (int k = 0; k < 5; k++) begin
      bus.ret = 1;
      tick();
      checks++; if (bus.address !== exp_ret[k]) begin failures++; $display("FAIL ovf_ret%0d got=%h exp=%h", k, bus.address, exp_ret[k]); end
    end
    idle();
    checks++; if (bus.ras_empty !== 1'b1) begin failures++; $display("FAIL ovf_empty got=%b exp=1", bus.ras_empty); end
    checks++; if (bus.ras_full !== 1'b0) begin failures++; $display("FAIL ovf_notfull got=%b exp=0", bus.ras_full); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.jump = 1; bus.jump_target = 16'hFFFF;
    tick();
    idle();
    checks++; if (bus.address !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff got=%h exp=ffff", bus.address); end
    tick();
    checks++; if (bus.address !== 16'h0000) begin failures++; $display("FAIL wrap_0000 got=%h exp=0000", bus.address); end
    checks++; if (bus.if_pc !== 16'hFFFF) begin failures++; $display("FAIL wrap_if_pc got=%h exp=ffff", bus.if_pc); end
    tick();
    checks++; if (bus.address !== 16'h0001) begin failures++; $display("FAIL wrap_0001 got=%h exp=0001", bus.address); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    repeat (3) tick();
    bus.call = 1; bus.jump = 1; bus.jump_target = 16'h0030;
    tick();
    idle();
    bus.stall_in = 1; bus.ret = 1;
    tick();
    checks++; if (bus.address !== 16'h0030) begin failures++; $display("FAIL ms_hold got=%h exp=0030", bus.address); end
    checks++; if (bus.ras_empty !== 1'b0) begin failures++; $display("FAIL ms_ras_frozen got=%b exp=0", bus.ras_empty); end
    #2;
    rst_n = 0;
    #1;
    checks++; if (bus.address !== 16'h0000) begin failures++; $display("FAIL ms_address got=%h exp=0000", bus.address); end
    checks++; if (bus.if_pc !== 16'h0000) begin failures++; $display("FAIL ms_if_pc got=%h exp=0000", bus.if_pc); end
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL ms_valid got=%b exp=0", bus.if_valid); end
    checks++; if (bus.ras_empty !== 1'b1) begin failures++; $display("FAIL ms_ras_empty got=%b exp=1", bus.ras_empty); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL ms_stall got=%b exp=0", bus.stall); end
    idle();
    tick();
    rst_n = 1;
    #1;
  endtask

  initial begin
    idle();
    test_reset();
    test_free_run();
    test_stall();
    test_jump();
    test_call_ret();
    test_branch_priority();
    test_ras_overflow();
    test_wrap();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
